// File: rtl/e_alu_arb.sv
// e_alu_arb: shares one external E-stage ALU between the main pipeline
// (port 0) and the auxiliary issue path (port 1). Round-robin grant,
// registered operand issue, and a one-entry result buffer per port.
// Optional build macro: ALU_ARB_OV_EN -- when defined, the overflow flag
// is captured for add/sub results; otherwise rsp*_ov is tied to zero.
module e_alu_arb #(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           req0_valid,
    input  logic [OPW-1:0] req0_op,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [OPW-1:0] req1_op,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           req1_ready,
    output logic [OPW-1:0] alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic [W-1:0]   alu_y,
    input  logic           alu_ov,
    output logic           rsp0_valid,
    output logic [W-1:0]   rsp0_y,
    output logic           rsp0_ov,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    output logic [W-1:0]   rsp1_y,
    output logic           rsp1_ov,
    input  logic           rsp1_ready
);

    // Issue register (what the ALU is evaluating this cycle)
    logic           iss_vld_r;
    logic           iss_id_r;
    logic [OPW-1:0] alu_op_r;
    logic [W-1:0]   alu_a_r;
    logic [W-1:0]   alu_b_r;

    // Round-robin pointer: port that wins the next contention
    logic           rr_r;

    // Per-port result buffers
    logic           rsp0_valid_r;
    logic [W-1:0]   rsp0_y_r;
    logic           rsp1_valid_r;
    logic [W-1:0]   rsp1_y_r;

    // Combinational arbitration terms
    logic           busy0_s;
    logic           busy1_s;
    logic           elig0_s;
    logic           elig1_s;
    logic           gnt0_s;
    logic           gnt1_s;
    logic           any_gnt_s;
    logic           cmpl0_s;
    logic           cmpl1_s;

    // Eligibility, round-robin grant and completion decode
    always_comb begin
        busy0_s = iss_vld_r & (iss_id_r == 1'b0);
        busy1_s = iss_vld_r & (iss_id_r == 1'b1);
        // A port may issue only when its buffer is free or drains this cycle,
        // which keeps at most one op in flight plus one buffered per port.
        elig0_s = reset & ~flush & req0_valid & ~busy0_s & (~rsp0_valid_r | rsp0_ready);
        elig1_s = reset & ~flush & req1_valid & ~busy1_s & (~rsp1_valid_r | rsp1_ready);
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        if (elig0_s && elig1_s) begin
            if (rr_r) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b1;
            end
        end else if (elig0_s) begin
            gnt0_s = 1'b1;
        end else if (elig1_s) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
        any_gnt_s = gnt0_s | gnt1_s;
        cmpl0_s   = busy0_s & ~flush;
        cmpl1_s   = busy1_s & ~flush;
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;
    assign alu_op     = alu_op_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp0_y     = rsp0_y_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp1_y     = rsp1_y_r;

    // Issue register: load on grant, otherwise the op retires after one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iss_vld_r <= 1'b0;
            iss_id_r  <= 1'b0;
            alu_op_r  <= '0;
            alu_a_r   <= '0;
            alu_b_r   <= '0;
        end else if (flush) begin
            iss_vld_r <= 1'b0;
        end else if (any_gnt_s) begin
            iss_vld_r <= 1'b1;
            iss_id_r  <= gnt1_s;
            alu_op_r  <= gnt1_s ? req1_op : req0_op;
            alu_a_r   <= gnt1_s ? req1_a  : req0_a;
            alu_b_r   <= gnt1_s ? req1_b  : req0_b;
        end else begin
            // Operands deliberately hold their last value when idle
            iss_vld_r <= 1'b0;
        end
    end

    // Round-robin pointer: after a grant, favour the port that lost
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_r <= 1'b0;
        end else if (any_gnt_s) begin
            rr_r <= ~gnt1_s;
        end else begin
            rr_r <= rr_r;
        end
    end

    // Port 0 result buffer: a new result wins over a same-edge pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp0_valid_r <= 1'b0;
            rsp0_y_r     <= '0;
        end else if (flush) begin
            rsp0_valid_r <= 1'b0;
        end else if (cmpl0_s) begin
            rsp0_valid_r <= 1'b1;
            rsp0_y_r     <= alu_y;
        end else if (rsp0_valid_r && rsp0_ready) begin
            rsp0_valid_r <= 1'b0;
        end else begin
            rsp0_valid_r <= rsp0_valid_r;
        end
    end

    // Port 1 result buffer: a new result wins over a same-edge pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp1_valid_r <= 1'b0;
            rsp1_y_r     <= '0;
        end else if (flush) begin
            rsp1_valid_r <= 1'b0;
        end else if (cmpl1_s) begin
            rsp1_valid_r <= 1'b1;
            rsp1_y_r     <= alu_y;
        end else if (rsp1_valid_r && rsp1_ready) begin
            rsp1_valid_r <= 1'b0;
        end else begin
            rsp1_valid_r <= rsp1_valid_r;
        end
    end

`ifdef ALU_ARB_OV_EN
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0001);

    logic rsp0_ov_r;
    logic rsp1_ov_r;

    // The ALU overflow flag is only meaningful for add and sub
    function automatic logic ov_qualify(input logic [OPW-1:0] op, input logic ov);
        return ((op == OP_ADD) || (op == OP_SUB)) ? ov : 1'b0;
    endfunction

    // Port 0 overflow capture alongside the result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp0_ov_r <= 1'b0;
        end else if (cmpl0_s) begin
            rsp0_ov_r <= ov_qualify(alu_op_r, alu_ov);
        end else begin
            rsp0_ov_r <= rsp0_ov_r;
        end
    end

    // Port 1 overflow capture alongside the result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp1_ov_r <= 1'b0;
        end else if (cmpl1_s) begin
            rsp1_ov_r <= ov_qualify(alu_op_r, alu_ov);
        end else begin
            rsp1_ov_r <= rsp1_ov_r;
        end
    end

    assign rsp0_ov = rsp0_ov_r;
    assign rsp1_ov = rsp1_ov_r;
`else
    // Overflow reporting disabled: flag is ignored and outputs tied low
    logic unused_alu_ov_s;
    assign unused_alu_ov_s = alu_ov;
    assign rsp0_ov = 1'b0;
    assign rsp1_ov = 1'b0;
`endif

endmodule

// File: tb/tb_e_alu_arb.sv
// Directed testbench for e_alu_arb. Models the external ALU
// (add / sub / and / others yield 0) and checks against hand-computed values.
module tb_e_alu_arb;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_y;
    logic        alu_ov;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_y, rsp1_y;
    logic        rsp0_ov, rsp1_ov;
    logic        rsp0_ready, rsp1_ready;

    int vec_cnt = 0;
    int err_cnt = 0;

`ifdef ALU_ARB_OV_EN
    localparam logic OV_EN = 1'b1;
`else
    localparam logic OV_EN = 1'b0;
`endif

    e_alu_arb #(.W(32), .OPW(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_ov(alu_ov),
        .rsp0_valid(rsp0_valid), .rsp0_y(rsp0_y), .rsp0_ov(rsp0_ov), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_y(rsp1_y), .rsp1_ov(rsp1_ov), .rsp1_ready(rsp1_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model; for AND it still raises the add-overflow flag so
    // the block's add/sub qualification is observable.
    logic [31:0] sum_s;
    always_comb begin
        sum_s  = alu_a + alu_b;
        alu_y  = 32'd0;
        alu_ov = 1'b0;
        case (alu_op)
            4'b0000: begin
                alu_y  = sum_s;
                alu_ov = (alu_a[31] == alu_b[31]) && (sum_s[31] != alu_a[31]);
            end
            4'b0001: begin
                alu_y  = alu_a - alu_b;
                alu_ov = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
            end
            4'b0010: begin
                alu_y  = alu_a & alu_b;
                alu_ov = (alu_a[31] == alu_b[31]) && (sum_s[31] != alu_a[31]);
            end
            default: begin
                alu_y  = 32'd0;
                alu_ov = 1'b0;
            end
        endcase
    end

    task automatic apply_reset;
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0; flush = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 32'd1; req1_b = 32'd1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        vec_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready); end
        vec_cnt++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_valid: got %b%b expected 00", rsp0_valid, rsp1_valid); end
        vec_cnt++; if (alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin err_cnt++; $display("FAIL reset_alu: got %h %h %h expected zeros", alu_op, alu_a, alu_b); end
        vec_cnt++; if (rsp0_y !== 32'd0 || rsp0_ov !== 1'b0 || rsp1_y !== 32'd0) begin err_cnt++; $display("FAIL reset_rsp_data: got %h %b %h expected zeros", rsp0_y, rsp0_ov, rsp1_y); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_basic;
        apply_reset();
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        vec_cnt++; if (req0_ready !== 1'b1) begin err_cnt++; $display("FAIL basic_ready: got %b expected 1", req0_ready); end
        @(posedge clk); #1;
        vec_cnt++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op !== 4'd0) begin err_cnt++; $display("FAIL basic_issue: got %h %h %h expected 0 5 7", alu_op, alu_a, alu_b); end
        vec_cnt++; if (rsp0_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_early: got %b expected 0", rsp0_valid); end
        @(negedge clk); req0_valid = 1'b0;
        @(posedge clk); #1;
        vec_cnt++; if (rsp0_valid !== 1'b1 || rsp0_y !== 32'd12 || rsp0_ov !== 1'b0) begin err_cnt++; $display("FAIL basic_rsp: got v=%b y=%h ov=%b expected 1 c 0", rsp0_valid, rsp0_y, rsp0_ov); end
        @(posedge clk); #1;
        vec_cnt++; if (rsp0_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_pop: got %b expected 0", rsp0_valid); end
    endtask

    task automatic test_alternate;
        apply_reset();
        req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 32'd10; req0_b = 32'd3;
        req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 32'd1;  req1_b = 32'd2;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            vec_cnt++;
            if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                err_cnt++; $display("FAIL alt_grant[%0d]: got %b%b expected %b%b", k, req0_ready, req1_ready, (k % 2 == 0), (k % 2 == 1));
            end
            if (k >= 2) begin
                vec_cnt++;
                if (rsp0_valid !== (k % 2 == 0) || rsp1_valid !== (k % 2 == 1)) begin
                    err_cnt++; $display("FAIL alt_rsp_valid[%0d]: got %b%b", k, rsp0_valid, rsp1_valid);
                end
                vec_cnt++;
                if ((k % 2 == 0) ? (rsp0_y !== 32'd7) : (rsp1_y !== 32'hFFFF_FFFF)) begin
                    err_cnt++; $display("FAIL alt_rsp_y[%0d]: got %h / %h expected 7 / ffffffff", k, rsp0_y, rsp1_y);
                end
            end
        end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_backpressure;
        apply_reset();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd1; req0_b = 32'd2;
        #1;
        vec_cnt++; if (req0_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_first_ready: got %b expected 1", req0_ready); end
        @(negedge clk);
        req0_a = 32'd100; req0_b = 32'd200;
        #1;
        vec_cnt++; if (req0_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_busy_ready: got %b expected 0", req0_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            vec_cnt++;
            if (req0_ready !== 1'b0 || rsp0_valid !== 1'b1 || rsp0_y !== 32'd3) begin
                err_cnt++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b y=%h expected 0 1 3", k, req0_ready, rsp0_valid, rsp0_y);
            end
        end
        @(negedge clk); rsp0_ready = 1'b1; #1;
        vec_cnt++; if (req0_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_release_ready: got %b expected 1", req0_ready); end
        @(negedge clk); rsp0_ready = 1'b0; req0_valid = 1'b0; #1;
        vec_cnt++; if (rsp0_valid !== 1'b0 || alu_a !== 32'd100) begin err_cnt++; $display("FAIL bp_second_issue: got v=%b a=%h expected 0 64", rsp0_valid, alu_a); end
        @(posedge clk); #1;
        vec_cnt++; if (rsp0_valid !== 1'b1 || rsp0_y !== 32'd300) begin err_cnt++; $display("FAIL bp_second_rsp: got v=%b y=%h expected 1 12c", rsp0_valid, rsp0_y); end
        @(negedge clk); rsp0_ready = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_ov;
        @(negedge clk);
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1;
        @(negedge clk); req0_valid = 1'b0;
        @(posedge clk); #1;
        vec_cnt++; if (rsp0_valid !== 1'b1 || rsp0_y !== 32'h8000_0000 || rsp0_ov !== OV_EN) begin err_cnt++; $display("FAIL ov_add: got v=%b y=%h ov=%b expected 1 80000000 %b", rsp0_valid, rsp0_y, rsp0_ov, OV_EN); end
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 4'b0010;
        @(negedge clk); req0_valid = 1'b0;
        @(posedge clk); #1;
        vec_cnt++; if (rsp0_valid !== 1'b1 || rsp0_y !== 32'd1 || rsp0_ov !== 1'b0) begin err_cnt++; $display("FAIL ov_and: got v=%b y=%h ov=%b expected 1 1 0", rsp0_valid, rsp0_y, rsp0_ov); end
        @(posedge clk);
    endtask

    task automatic test_flush;
        apply_reset();
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd2; req0_b = 32'd3;
        #1;
        vec_cnt++; if (req0_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_accept: got %b expected 1", req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 32'd4; req1_b = 32'd4;
        flush = 1'b1; #1;
        vec_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin err_cnt++; $display("FAIL flush_no_grant: got %b%b expected 00", req0_ready, req1_ready); end
        @(negedge clk); flush = 1'b0; req1_valid = 1'b0; #1;
        vec_cnt++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_valid: got %b%b expected 00", rsp0_valid, rsp1_valid); end
        @(posedge clk); #1;
        vec_cnt++; if (rsp0_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_dropped: got %b expected 0", rsp0_valid); end
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        vec_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_rr_kept: got %b%b expected 01", req0_ready, req1_ready); end
        @(negedge clk); req1_valid = 1'b0; #1;
        vec_cnt++; if (req0_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_next_grant: got %b expected 1", req0_ready); end
        @(negedge clk); req0_valid = 1'b0; #1;
        vec_cnt++; if (rsp1_valid !== 1'b1 || rsp1_y !== 32'd8) begin err_cnt++; $display("FAIL flush_rsp1: got v=%b y=%h expected 1 8", rsp1_valid, rsp1_y); end
        @(posedge clk); #1;
        vec_cnt++; if (rsp0_valid !== 1'b1 || rsp0_y !== 32'd5) begin err_cnt++; $display("FAIL flush_rsp0: got v=%b y=%h expected 1 5", rsp0_valid, rsp0_y); end
        @(posedge clk);
    endtask

    task automatic test_reset_mid;
        apply_reset();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 32'd2; req1_b = 32'd2;
        @(negedge clk); @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; #1;
        vec_cnt++; if (rsp0_valid !== 1'b1 || rsp0_y !== 32'd2) begin err_cnt++; $display("FAIL rstmid_pre: got v=%b y=%h expected 1 2", rsp0_valid, rsp0_y); end
        #2;
        reset = 1'b0; req0_valid = 1'b1; #1;
        vec_cnt++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_async: got %b%b expected 00", rsp0_valid, rsp1_valid); end
        vec_cnt++; if (req0_ready !== 1'b0 || alu_a !== 32'd0) begin err_cnt++; $display("FAIL rstmid_state: got rdy=%b a=%h expected 0 0", req0_ready, alu_a); end
        @(negedge clk); reset = 1'b1; req0_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        vec_cnt++; if (rsp1_valid !== 1'b0 || rsp0_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_no_partial: got %b%b expected 00", rsp0_valid, rsp1_valid); end
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        vec_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin err_cnt++; $display("FAIL rstmid_rr: got %b%b expected 10", req0_ready, req1_ready); end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_backpressure();
        test_ov();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/e_alu_arb.md
Name: e_alu_arb

Overview:
- Shares one E-stage ALU between two requesters: port 0 is the main pipeline, port 1 is the auxiliary issue path.
- Round-robin arbitration, registered operand issue, and a per-port result buffer with valid/ready handshakes.
- The ALU itself is external. This block drives its op/A/B and captures Y and the overflow flag.

Parameters:
- W, 32, operand/result width.
- OPW, 4, ALU op-code width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous active-low reset; 0 = reset.
- flush  in  1  synchronous; drops in-flight op and buffered results.
- req0_valid  in  1  port 0 request.
- req0_op  in  OPW  port 0 ALU op.
- req0_a  in  W  port 0 operand A.
- req0_b  in  W  port 0 operand B.
- req0_ready  out  1  port 0 accept.
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as port 0, for port 1.
- alu_op  out  OPW  registered op to ALU.
- alu_a  out  W  registered A to ALU.
- alu_b  out  W  registered B to ALU.
- alu_y  in  W  ALU result.
- alu_ov  in  1  ALU signed-overflow flag (valid for add/sub only).
- rsp0_valid  out  1  port 0 result available.
- rsp0_y  out  W  port 0 result.
- rsp0_ov  out  1  port 0 overflow.
- rsp0_ready  in  1  port 0 consumer accept.
- rsp1_valid, rsp1_y, rsp1_ov, rsp1_ready  same as port 0, for port 1.

Behaviour:
- Reset (reset=0, asynchronous):
  - Issue register cleared: iss_vld=0, iss_id=0, alu_op/alu_a/alu_b=0.
  - rsp*_valid=0, rsp*_y=0, rsp*_ov=0.
  - Round-robin pointer rr=0.
  - req*_ready low during reset.
- Eligibility of port i: req_i_valid=1, no op of port i in the issue register, and (rsp_i_valid=0 or rsp_i_ready=1 this cycle).
- Grant:
  - Only one port eligible: it wins.
  - Both eligible: port rr wins.
  - After a grant, rr becomes the index of the non-granted port.
  - rr is unchanged when there is no grant.
- req_i_ready = grant_i (combinational). A handshake is req_i_valid & req_i_ready.
- Latency:
  - Handshake at edge E0 loads the issue register: op, a, b, id, iss_vld=1.
  - The ALU evaluates during the following cycle.
  - Edge E1 loads rsp_id_y/ov from alu_y/alu_ov and sets rsp_id_valid=1.
  - Two edges from accept to rsp_valid. Throughput is 1 op/cycle across both ports.
- iss_vld clears at E1 unless a new grant loads it at the same edge (back-to-back allowed).
- rsp_i_valid clears on rsp_i_valid & rsp_i_ready, unless a new result for port i loads at the same edge; in that case the new result wins and valid stays 1.
- Response stability: rsp_i_y/ov hold stable while rsp_i_valid=1 and rsp_i_ready=0.
- Per-port ordering: a port never has more than one op in flight plus one buffered, so responses are in order.
- Illegal op codes (ALU yields 0): passed through unchanged. No checking here.
- flush=1 at an edge:
  - iss_vld=0 and rsp*_valid=0. Data registers keep their values.
  - No grant occurs that cycle; req*_ready=0.
  - rr is unchanged.
- Reset asserted mid-operation: everything is lost. There is no partial completion after release.
- alu_a/alu_b/alu_op hold their last value when iss_vld=0; they are not zeroed.

Optional Feature:
- Macro ALU_ARB_OV_EN.
- Defined: rsp_i_ov captures alu_ov at E1, but only for op 4'b0000 (add) and 4'b0001 (sub); for all other ops it is captured as 0.
- Not defined: rsp*_ov is constant 0, alu_ov is unused, and no overflow storage is synthesized.

Test Plan:
- Reset, then port 0 requests op=0000, a=5, b=7; rsp0_ready=1 -> req0_ready=1 in that cycle; rsp0_valid=1 two edges later with rsp0_y=12, rsp0_ov=0.
- Both ports valid every cycle with op=0001; port 0 a=10 b=3, port 1 a=1 b=2 -> grants alternate 0,1,0,1; rsp0_y=7, rsp1_y=0xFFFFFFFF.
- Port 0 issues twice with rsp0_ready=0 -> first result held stable; second request waits with req0_ready=0; after rsp0_ready=1 for one cycle the second op is accepted.
- ALU_ARB_OV_EN defined, op=0000, a=0x7FFFFFFF, b=1 -> rsp0_y=0x80000000, rsp0_ov=1. Same operands with op=0010 -> rsp0_ov=0. Macro undefined -> rsp0_ov=0 in both cases.
- flush asserted the edge after an accept -> that op never responds; rsp*_valid=0; no grant in the flush cycle; the next request completes normally.
- reset pulsed low while both rsp valid and one op is in flight -> all valids 0 immediately, without waiting for a clock edge; rr=0 after release, so port 0 wins the first contention.
